multdiv_seq: RTL and testbench

Sequential signed 32-bit multiply/divide unit that answers the processor's multdiv request interface. The processor pulses `ctrl_MULT` or `ctrl_DIV` with operands. The unit iterates over a fixed number of cycles, then returns the result, an exception flag and a one-cycle `data_resultRDY` strobe. It sits beside the ALU in the execute stage, and the processor stalls on it until the strobe arrives.

---
 rtl/multdiv_seq_if.sv | 30 +++
 rtl/multdiv_seq.sv | 165 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/multdiv_seq_if.sv
// multdiv_seq_if
// Request/response bundle between the processor execute stage and the
// sequential multiply/divide unit.
//   data_operandA  : multiplicand / dividend (two's complement)
//   data_operandB  : multiplier / divisor (two's complement)
//   ctrl_MULT      : one-cycle multiply start pulse
//   ctrl_DIV       : one-cycle divide start pulse
//   data_result    : 32-bit result, held until the next start
//   data_exception : overflow or divide-by-zero flag
//   data_resultRDY : one-cycle completion strobe
// master = processor side, slave = multdiv unit side.
interface multdiv_seq_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq.sv
// multdiv_seq
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring,
// on magnitudes). Fixed 33-cycle latency from the start edge to the
// completion strobe, for every operand value.
// Ports:
//   clock : master clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : multdiv_seq_if.slave (operands, start pulses, result/exception/RDY)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a start; result/exception hold last completion
// MULT   | Booth iterations, r_cnt counts completed steps (0..32)
// DIV    | restoring-division iterations, r_cnt counts completed steps
// DONE   | result valid, data_resultRDY high for this one cycle
module multdiv_seq (
    input  logic          clock,
    input  logic          reset,
    multdiv_seq_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] ITERS = 6'd32;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_prod;     // {product[63:0], q-1}
    logic [31:0] r_mcand;
    logic [63:0] r_rq;       // {remainder, quotient}
    logic [31:0] r_dvsr;     // |divisor|
    logic        r_neg;
    logic        r_dbz;
    logic        r_dovf;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;

    logic        w_start;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_hi33;
    logic [32:0] w_m33;
    logic [32:0] w_sum33;
    logic [64:0] w_booth_next;
    logic [31:0] w_mres;
    logic        w_movf;
    logic [63:0] w_rq_sh;
    logic [32:0] w_trial;
    logic [63:0] w_rq_next;
    logic [31:0] w_quo;
    logic [31:0] w_dres;
    logic        w_dexc;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign w_abs_a = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
    assign w_abs_b = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

    // Booth step: the add is carried in 33 bits so a -2^31 multiplicand
    // cannot overflow the partial product before the arithmetic shift.
    assign w_hi33 = {r_prod[64], r_prod[64:33]};
    assign w_m33  = {r_mcand[31], r_mcand};

    always_comb begin
        w_sum33 = w_hi33;
        case (r_prod[1:0])
            2'b01:   w_sum33 = w_hi33 + w_m33;
            2'b10:   w_sum33 = w_hi33 - w_m33;
            default: w_sum33 = w_hi33;
        endcase
    end

    assign w_booth_next = {w_sum33, r_prod[32:1]};
    assign w_mres       = r_prod[32:1];
    assign w_movf       = (r_prod[64:33] != {32{r_prod[32]}});

    // Restoring step. The remainder stays below |divisor| <= 2^31, so the
    // bit shifted out of r_rq[63] is always zero.
    assign w_rq_sh = {r_rq[62:0], 1'b0};
    assign w_trial = {1'b0, w_rq_sh[63:32]} - {1'b0, r_dvsr};

    always_comb begin
        w_rq_next = w_rq_sh;
        if (!w_trial[32]) begin
            w_rq_next = {w_trial[31:0], w_rq_sh[31:1], 1'b1};
        end
    end

    // Divide-by-zero overrides the meaningless iteration result. The
    // 0x80000000 / -1 case already yields 0x80000000 from the magnitude
    // quotient, only its exception flag needs forcing.
    assign w_quo  = r_rq[31:0];
    assign w_dres = r_dbz ? 32'd0 : (r_neg ? (32'd0 - w_quo) : w_quo);
    assign w_dexc = r_dbz | r_dovf;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_prod   <= 65'd0;
            r_mcand  <= 32'd0;
            r_rq     <= 64'd0;
            r_dvsr   <= 32'd0;
            r_neg    <= 1'b0;
            r_dbz    <= 1'b0;
            r_dovf   <= 1'b0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else if (w_start) begin
            // A start in any state abandons whatever was in progress.
            r_state <= bus.ctrl_MULT ? S_MULT : S_DIV;
            r_cnt   <= 6'd0;
            r_prod  <= {32'd0, bus.data_operandB, 1'b0};
            r_mcand <= bus.data_operandA;
            r_rq    <= {32'd0, w_abs_a};
            r_dvsr  <= w_abs_b;
            r_neg   <= bus.data_operandA[31] ^ bus.data_operandB[31];
            r_dbz   <= (bus.data_operandB == 32'd0);
            r_dovf  <= (bus.data_operandA == 32'h8000_0000) &&
                       (bus.data_operandB == 32'hFFFF_FFFF);
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                S_MULT: begin
                    if (r_cnt == ITERS) begin
                        r_result <= w_mres;
                        r_exc    <= w_movf;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_prod <= w_booth_next;
                        r_cnt  <= r_cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == ITERS) begin
                        r_result <= w_dres;
                        r_exc    <= w_dexc;
                        r_rdy    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_rq  <= w_rq_next;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    r_rdy   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq
// Scoreboard bench for multdiv_seq: stimulus pushes the expected response
// (from plain 64-bit arithmetic) into a queue, a negedge monitor pops and
// compares whenever the completion strobe is seen.
module tb_multdiv_seq;
    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          e0;
        string       nm;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    exp_t sbq[$];
    exp_t mon_e;

    multdiv_seq_if bus();

    multdiv_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tot++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    endtask

    function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.e0 = 0;
        r.nm = "";
        if (is_mult) begin
            p = sa * sb;
            r.res = p[31:0];
            r.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            r.res = 32'd0;
            r.exc = 1'b1;
        end else begin
            p = sa / sb;
            r.res = p[31:0];
            r.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end
        return r;
    endfunction

    // Called just after a negedge; the following posedge is E0.
    task automatic issue(input bit m, input bit d, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
        exp_t e;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        e    = model(m, a, b);
        e.e0 = cyc + 1;
        e.nm = nm;
        sbq.push_back(e);
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) seen = 1'b1;
        end
        chk({"strobe_seen_", nm}, {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] sp [5];
        sp[0] = 32'h0000_0000;
        sp[1] = 32'h0000_0001;
        sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000;
        sp[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 300));
            2:       return 32'd0 - 32'($urandom_range(1, 300));
            3:       return sp[$urandom_range(0, 4)];
            default: return 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
        endcase
    endfunction

    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("strobe_without_pending_op", 32'(sbq.size()), 32'd1);
            end else begin
                mon_e = sbq.pop_front();
                chk({"result_", mon_e.nm}, bus.data_result, mon_e.res);
                chk({"exception_", mon_e.nm}, {31'd0, bus.data_exception}, {31'd0, mon_e.exc});
                chk({"latency_", mon_e.nm}, 32'(cyc - mon_e.e0), 32'd33);
            end
        end
    end

    initial begin
        bus.data_operandA = 32'd0;
        bus.data_operandB = 32'd0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;

        repeat (3) @(negedge clock);
        chk("reset_result", bus.data_result, 32'd0);
        chk("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Basic multiply, then idle past E40 so any stray strobe is caught.
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
        wait_done("mul_7_m3");
        repeat (8) @(negedge clock);

        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        wait_done("mul_ovf");
        issue(1'b1, 1'b0, 32'h0000_8000, 32'hFFFF_0000, "mul_min");
        wait_done("mul_min");
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        wait_done("div_m7_2");
        issue(1'b0, 1'b1, 32'd100, 32'd7, "div_100_7");
        wait_done("div_100_7");
        issue(1'b0, 1'b1, 32'd5, 32'd0, "div_by_zero");
        wait_done("div_by_zero");
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        wait_done("div_ovf");

        // Restart: MULT at E0 is abandoned by a DIV at E10.
        issue(1'b1, 1'b0, 32'd3, 32'd4, "mul_abandoned");
        repeat (10) @(negedge clock);
        void'(sbq.pop_back());
        issue(1'b0, 1'b1, 32'd9, 32'd3, "div_restart");
        wait_done("div_restart");

        issue(1'b1, 1'b1, 32'd6, 32'd2, "mul_div_both");
        wait_done("mul_div_both");

        // Asynchronous reset in the middle of a divide.
        issue(1'b0, 1'b1, 32'd1000, 32'd7, "div_reset");
        repeat (15) @(negedge clock);
        #2;
        reset = 1'b0;
        void'(sbq.pop_back());
        #1;
        chk("async_reset_result", bus.data_result, 32'd0);
        chk("async_reset_exception", {31'd0, bus.data_exception}, 32'd0);
        chk("async_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        issue(1'b1, 1'b0, 32'd2, 32'd2, "mul_after_reset");
        wait_done("mul_after_reset");

        // Randomized back-to-back traffic.
        for (int i = 0; i < 60; i++) begin
            bit m;
            m = 1'($urandom_range(0, 1));
            issue(m, ~m, rnd_opnd(), rnd_opnd(), m ? "rand_mul" : "rand_div");
            wait_done("rand");
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
